// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase
//   Centisecond timebase and MM:SS.cc BCD time-keeping for the stopwatch.
//   A prescaler divides clk down to TICK_HZ. Each tick advances six BCD
//   digits through a single-cycle ripple carry chain that wraps from
//   59:59.99 to 00:00.00.
//
// Parameters
//   CLK_HZ   system clock frequency in Hz
//   TICK_HZ  timebase tick rate in Hz (100 gives centisecond resolution)
//
// Ports
//   clk        system clock
//   reset      asynchronous active-high reset
//   clr        synchronous clear from the control FSM (beats count)
//   count      run enable from the control FSM
//   lap        single-cycle lap pulse (only used with STOPWATCH_LAP_EN)
//   cs_ones .. min_tens   BCD display digits, all registered
//   tick       one-cycle pulse on every centisecond increment
//   wrap       one-cycle pulse when 59:59.99 rolls over to 00:00.00
//   lap_active high while the display is frozen by lap
//
// Optional feature
//   Define STOPWATCH_LAP_EN to add a shadow digit register set that can be
//   frozen by lap while the live counters keep running. Without the macro
//   lap is ignored, lap_active is tied low and no shadow flops exist.

module stopwatch_timebase #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       count,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       tick,
  output logic       wrap,
  output logic       lap_active
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  // Highest legal value per digit, index 0 = cs_ones ... 5 = min_tens
  localparam logic [5:0][3:0] DIG_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  generate
    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_cfg
      $fatal(1, "stopwatch_timebase: CLK_HZ must be a multiple of TICK_HZ with CLK_HZ/TICK_HZ >= 2");
    end
  endgenerate

  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic [6:0]      carry;
  logic [5:0][3:0] disp;

  // Prescaler and digit carry chain. carry[0] is the tick enable and
  // carry[i+1] is the carry out of digit i, so a full rollover of every
  // digit resolves within one cycle. Holding count low keeps the prescaler
  // phase, so a pause loses no fractional time.
  always_comb begin
    presc_d = presc_q;
    dig_d   = dig_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    carry   = '0;
    if (clr) begin
      presc_d = '0;
      dig_d   = '0;
    end else if (count) begin
      if (presc_q == PRESC_LAST) begin
        presc_d  = '0;
        carry[0] = 1'b1;
        tick_d   = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
      for (int i = 0; i < 6; i++) begin
        if (carry[i]) begin
          if (dig_q[i] >= DIG_MAX[i]) begin
            dig_d[i]   = 4'd0;
            carry[i+1] = 1'b1;
          end else begin
            dig_d[i] = dig_q[i] + 4'd1;
          end
        end
      end
      wrap_d = carry[6];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      dig_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic            lap_active_q, lap_active_d;
  logic [5:0][3:0] shadow_q, shadow_d;

  // The shadow loads the next live value on every edge except while the
  // display stays frozen (lap_active high before and after the edge). This
  // captures the same-edge increment on freeze and shows live digits
  // immediately after unfreeze.
  always_comb begin
    lap_active_d = lap_active_q;
    shadow_d     = shadow_q;
    if (clr) begin
      lap_active_d = 1'b0;
      shadow_d     = '0;
    end else begin
      if (lap) begin
        lap_active_d = ~lap_active_q;
      end
      if (!(lap_active_q && lap_active_d)) begin
        shadow_d = dig_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_active_q <= 1'b0;
      shadow_q     <= '0;
    end else begin
      lap_active_q <= lap_active_d;
      shadow_q     <= shadow_d;
    end
  end

  assign disp       = shadow_q;
  assign lap_active = lap_active_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = dig_q;
  assign lap_active = 1'b0;
`endif

  assign cs_ones  = disp[0];
  assign cs_tens  = disp[1];
  assign sec_ones = disp[2];
  assign sec_tens = disp[3];
  assign min_ones = disp[4];
  assign min_tens = disp[5];
  assign tick     = tick_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// tb_stopwatch_timebase
//   Self-checking bench for stopwatch_timebase at CLK_HZ=1000, TICK_HZ=100
//   (DIV=10). A behavioural model keeps elapsed time as a plain count of
//   centiseconds plus a prescaler phase; every driven cycle pushes the
//   expected outputs to a queue, and each test pops and compares after the
//   clock edge. Long preloads (00:59.99, 12:34.56, 59:59.99) are applied by
//   briefly forcing the live digit register between clock edges.
//   Define STOPWATCH_LAP_EN for both files to exercise the lap feature.

module tb_stopwatch_timebase;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int FULL_CS = 360000;

  logic       clk = 1'b0;
  logic       reset, clr, count, lap;
  logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
  logic       tick, wrap, lap_active;

  stopwatch_timebase #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .count     (count),
    .lap       (lap),
    .cs_ones   (cs_ones),
    .cs_tens   (cs_tens),
    .sec_ones  (sec_ones),
    .sec_tens  (sec_tens),
    .min_ones  (min_ones),
    .min_tens  (min_tens),
    .tick      (tick),
    .wrap      (wrap),
    .lap_active(lap_active)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [26:0] exp_q[$];

  int m_cs, m_presc, m_shadow;
  bit m_lap_act;

  function automatic logic [23:0] to_bcd(int t);
    int mm, ss, cc;
    mm = t / 6000;
    ss = (t / 100) % 60;
    cc = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [26:0] observed();
    return {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones, tick, wrap, lap_active};
  endfunction

  task automatic model_reset();
    m_cs      = 0;
    m_presc   = 0;
    m_shadow  = 0;
    m_lap_act = 0;
  endtask

  // Drive one cycle of inputs, advance the model, queue the expected
  // outputs and step to 1 time unit after the next rising edge.
  task automatic drive_cycle(input bit c_clr, input bit c_count, input bit c_lap);
    bit t, w, old_lap;
    t       = 0;
    w       = 0;
    old_lap = m_lap_act;
    clr     = c_clr;
    count   = c_count;
    lap     = c_lap;
    if (c_clr) begin
      m_cs      = 0;
      m_presc   = 0;
      m_lap_act = 0;
    end else if (c_count) begin
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        t       = 1;
        w       = (m_cs == FULL_CS - 1);
        m_cs    = (m_cs + 1) % FULL_CS;
      end else begin
        m_presc++;
      end
    end
`ifdef STOPWATCH_LAP_EN
    if (!c_clr && c_lap) m_lap_act = !m_lap_act;
    if (!(old_lap && m_lap_act)) m_shadow = m_cs;
`else
    m_shadow = m_cs;
`endif
    exp_q.push_back({to_bcd(m_shadow), t, w, m_lap_act});
    @(posedge clk);
    #1;
  endtask

  // Jump the live counters to t centiseconds between two clock edges.
  task automatic preload(input int t);
    m_cs = t;
    force dut.dig_q = to_bcd(t);
    #1;
    release dut.dig_q;
  endtask

  task automatic test_reset();
    logic [26:0] got;
    reset = 1'b1;
    clr   = 1'b0;
    count = 1'b0;
    lap   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = observed();
    checks++;
    if (got !== 27'd0) $display("[TB] FAIL reset_state got=%h want=%h", got, 27'd0);
    else passed++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_tick_rate();
    logic [26:0] got, want;
    int ticks;
    drive_cycle(1, 0, 0);
    got = observed(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("[TB] FAIL clear_cycle got=%h want=%h", got, want);
    else passed++;
    ticks = 0;
    for (int i = 1; i <= 10 * DIV; i++) begin
      drive_cycle(0, 1, 0);
      if (tick === 1'b1) ticks++;
      got = observed(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("[TB] FAIL tick_rate cycle=%0d got=%h want=%h", i, got, want);
      else passed++;
    end
    checks++;
    if ({min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} !== 24'h000010 || ticks != 10)
      $display("[TB] FAIL ten_ticks digits=%h ticks=%0d want=000010 ticks=10",
               {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}, ticks);
    else passed++;
  endtask

  task automatic test_pause();
    logic [26:0] got, want;
    drive_cycle(1, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5 * DIV + 3; i++) begin
      drive_cycle(0, 1, 0);
      void'(exp_q.pop_front());
    end
    for (int i = 1; i <= 50; i++) begin
      drive_cycle(0, 0, 0);
      got = observed(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("[TB] FAIL pause_hold cycle=%0d got=%h want=%h", i, got, want);
      else passed++;
    end
    for (int i = 1; i <= 7; i++) begin
      drive_cycle(0, 1, 0);
      got = observed(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("[TB] FAIL resume edge=%0d got=%h want=%h", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_minute_carry();
    logic [26:0] got, want;
    drive_cycle(1, 0, 0);
    void'(exp_q.pop_front());
    preload(5999);
    for (int i = 1; i <= DIV; i++) begin
      drive_cycle(0, 1, 0);
      got = observed(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("[TB] FAIL minute_carry edge=%0d got=%h want=%h", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [26:0] got, want;
    drive_cycle(1, 0, 0);
    void'(exp_q.pop_front());
    preload(FULL_CS - 1);
    for (int i = 1; i <= 2 * DIV; i++) begin
      drive_cycle(0, 1, 0);
      got = observed(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("[TB] FAIL wrap edge=%0d got=%h want=%h", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_clear_priority();
    logic [26:0] got, want;
    drive_cycle(1, 0, 0);
    void'(exp_q.pop_front());
    preload(12 * 6000 + 34 * 100 + 56);
    for (int i = 0; i < DIV - 1; i++) begin
      drive_cycle(0, 1, 0);
      void'(exp_q.pop_front());
    end
    // Prescaler now sits on its last phase: clr must suppress the tick.
    drive_cycle(1, 1, 0);
    got = observed(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("[TB] FAIL clr_over_count got=%h want=%h", got, want);
    else passed++;
    for (int i = 1; i <= DIV; i++) begin
      drive_cycle(0, 1, 0);
      got = observed(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("[TB] FAIL post_clr_latency edge=%0d got=%h want=%h", i, got, want);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [26:0] got;
    drive_cycle(1, 0, 0);
    void'(exp_q.pop_front());
    preload(12 * 6000 + 34 * 100 + 56);
    for (int i = 0; i < DIV + 4; i++) begin
      drive_cycle(0, 1, 0);
      void'(exp_q.pop_front());
    end
    #2;
    reset = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== 27'd0) $display("[TB] FAIL async_reset_immediate got=%h want=%h", got, 27'd0);
    else passed++;
    @(posedge clk);
    #1;
    got = observed();
    checks++;
    if (got !== 27'd0) $display("[TB] FAIL async_reset_held got=%h want=%h", got, 27'd0);
    else passed++;
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= DIV; i++) begin
      drive_cycle(0, 1, 0);
      got = observed(); checks++;
      if (got !== exp_q.pop_front()) $display("[TB] FAIL after_reset edge=%0d got=%h", i, got);
      else passed++;
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    logic [26:0] got, want;
    int guard;
    drive_cycle(1, 0, 0);
    void'(exp_q.pop_front());
    preload(120);
    for (int i = 0; i < 3 * DIV; i++) begin
      drive_cycle(0, 1, 0);
      void'(exp_q.pop_front());
    end
    drive_cycle(0, 1, 1);
    got = observed(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("[TB] FAIL lap_freeze got=%h want=%h", got, want);
    else passed++;
    guard = 0;
    while (m_cs != 200 && guard < 2000) begin
      drive_cycle(0, 1, 0);
      guard++;
      got = observed(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("[TB] FAIL lap_frozen cycle=%0d got=%h want=%h", guard, got, want);
      else passed++;
    end
    drive_cycle(0, 1, 1);
    got = observed(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("[TB] FAIL lap_release got=%h want=%h", got, want);
    else passed++;
    drive_cycle(0, 1, 1);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 15; i++) begin
      drive_cycle(0, 1, 0);
      void'(exp_q.pop_front());
    end
    drive_cycle(1, 1, 1);
    got = observed(); want = exp_q.pop_front(); checks++;
    if (got !== want) $display("[TB] FAIL clr_during_lap got=%h want=%h", got, want);
    else passed++;
  endtask
`else
  task automatic test_lap_ignored();
    logic [26:0] got, want;
    drive_cycle(1, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 3 * DIV; i++) begin
      drive_cycle(0, 1, (i % 3) == 0);
      got = observed(); want = exp_q.pop_front(); checks++;
      if (got !== want) $display("[TB] FAIL lap_ignored cycle=%0d got=%h want=%h", i, got, want);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tick_rate();
    test_pause();
    test_minute_carry();
    test_wrap();
    test_clear_priority();
    test_async_reset();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`else
    test_lap_ignored();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
